// File: rtl/gcd_lcm_stage_if.sv
// Handshake bundle for the LCM stage: operand side (A, B, gcd_in) and result side (lcm, err).
interface gcd_lcm_stage_if #(
  parameter int unsigned WIDTH = 5
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [WIDTH-1:0]     gcd_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   lcm;
  logic                 err;

  // Upstream / sink side
  modport master (
    output in_valid, A, B, gcd_in, out_ready,
    input  in_ready, out_valid, lcm, err
  );

  // LCM stage side
  modport slave (
    input  in_valid, A, B, gcd_in, out_ready,
    output in_ready, out_valid, lcm, err
  );

endinterface

// File: rtl/gcd_lcm_stage.sv
// LCM stage: lcm = (A / gcd) * B using a restoring divider then a shift-add multiplier.
module gcd_lcm_stage #(
  parameter int unsigned WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst,
  gcd_lcm_stage_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StDiv, StMul, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;      // dividend, shifted left one bit per DIV cycle
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     g_q;
  logic [WIDTH:0]       rem_q;    // partial remainder
  logic [WIDTH-1:0]     quot_q;   // quotient; consumed LSB first during MUL
  logic [2*WIDTH-1:0]   mcand_q;  // B shifted left one bit per MUL cycle
  logic [2*WIDTH-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   lcm_q;
  logic                 err_q;
  logic                 out_valid_q;

  logic [WIDTH:0]       rem_shift;
  logic                 rem_ge;
  logic [WIDTH:0]       rem_next;
  logic [WIDTH-1:0]     quot_next;
  logic [2*WIDTH-1:0]   acc_next;

  // One restoring-division step and one shift-add step, selected by state
  always_comb begin
    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, a_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, g_q};
    rem_next  = rem_ge ? rem_shift - {1'b0, g_q} : rem_shift;
    quot_next = {quot_q[WIDTH-2:0], rem_ge};
    acc_next  = acc_q + (quot_q[0] ? mcand_q : '0);
  end

  // Control FSM, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      g_q         <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      lcm_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            g_q     <= bus.gcd_in;
            rem_q   <= '0;
            quot_q  <= '0;
            mcand_q <= {{WIDTH{1'b0}}, bus.B};
            acc_q   <= '0;
            cnt_q   <= '0;
            if (bus.gcd_in == '0) begin
              state_q <= StDone;
              lcm_q   <= '0;
              err_q   <= 1'b1;
            end else if (bus.A == '0 || bus.B == '0) begin
              state_q <= StDone;
              lcm_q   <= '0;
              err_q   <= 1'b0;
            end else begin
              state_q <= StDiv;
            end
          end
        end
        StDiv: begin
          a_q    <= a_q << 1;
          rem_q  <= rem_next;
          quot_q <= quot_next;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            // A nonzero remainder means gcd_in does not divide A
            if (rem_next != '0) begin
              state_q <= StDone;
              lcm_q   <= '0;
              err_q   <= 1'b1;
            end else begin
              state_q <= StMul;
            end
          end
        end
        StMul: begin
          acc_q   <= acc_next;
          mcand_q <= mcand_q << 1;
          quot_q  <= quot_q >> 1;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            state_q <= StDone;
            lcm_q   <= acc_next;
            err_q   <= 1'b0;
          end
        end
        StDone: begin
          // First DONE cycle raises out_valid; result then holds until the sink takes it
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.lcm       = lcm_q;
  assign bus.err       = err_q;

  // b_q is kept for debug visibility of the accepted operand set
  logic unused_b;
  assign unused_b = ^b_q;

endmodule

// File: tb/tb_gcd_lcm_stage.sv
// Directed bench for gcd_lcm_stage: vector table plus backpressure and mid-job reset sequences.
module tb_gcd_lcm_stage;

  localparam int unsigned W = 5;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  gcd_lcm_stage_if #(.WIDTH(W)) bus ();

  gcd_lcm_stage #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   g;
    logic [2*W-1:0] exp_lcm;
    logic           exp_err;
    int             exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Present one operand set from IDLE; returns edges from acceptance to out_valid high.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g,
                         output int lat);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.gcd_in   = g;
    bus.in_valid = 1'b1;
    check("in_ready before accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    n_cmp  = 0;
    n_fail = 0;

    vecs[0]  = '{a: 5'd24, b: 5'd18, g: 5'd6,  exp_lcm: 10'd72,  exp_err: 1'b0, exp_lat: 11};
    vecs[1]  = '{a: 5'd12, b: 5'd15, g: 5'd3,  exp_lcm: 10'd60,  exp_err: 1'b0, exp_lat: 11};
    vecs[2]  = '{a: 5'd10, b: 5'd15, g: 5'd5,  exp_lcm: 10'd30,  exp_err: 1'b0, exp_lat: 11};
    vecs[3]  = '{a: 5'd31, b: 5'd30, g: 5'd1,  exp_lcm: 10'd930, exp_err: 1'b0, exp_lat: 11};
    vecs[4]  = '{a: 5'd31, b: 5'd31, g: 5'd31, exp_lcm: 10'd31,  exp_err: 1'b0, exp_lat: 11};
    vecs[5]  = '{a: 5'd0,  b: 5'd7,  g: 5'd7,  exp_lcm: 10'd0,   exp_err: 1'b0, exp_lat: 1};
    vecs[6]  = '{a: 5'd0,  b: 5'd0,  g: 5'd0,  exp_lcm: 10'd0,   exp_err: 1'b1, exp_lat: 1};
    vecs[7]  = '{a: 5'd7,  b: 5'd0,  g: 5'd7,  exp_lcm: 10'd0,   exp_err: 1'b0, exp_lat: 1};
    vecs[8]  = '{a: 5'd5,  b: 5'd3,  g: 5'd0,  exp_lcm: 10'd0,   exp_err: 1'b1, exp_lat: 1};
    // 4 divides A=12 but not B=15; only A is checked, so 3*15 results
    vecs[9]  = '{a: 5'd12, b: 5'd15, g: 5'd4,  exp_lcm: 10'd45,  exp_err: 1'b0, exp_lat: 11};
    // 15/4 leaves remainder 3
    vecs[10] = '{a: 5'd15, b: 5'd12, g: 5'd4,  exp_lcm: 10'd0,   exp_err: 1'b1, exp_lat: 6};

    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.gcd_in    = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    #12;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset lcm", 32'(bus.lcm), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_job(vecs[i].a, vecs[i].b, vecs[i].g, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d lcm", i), 32'(bus.lcm), 32'(vecs[i].exp_lcm));
      check($sformatf("vec%0d err", i), 32'(bus.err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d in_ready busy", i), 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid drop", i), 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: result held, next job waiting on in_valid must not slip in
    bus.out_ready = 1'b0;
    run_job(5'd24, 5'd18, 5'd6, lat);
    check("bp latency", 32'(lat), 32'd11);
    bus.A        = 5'd12;
    bus.B        = 5'd15;
    bus.gcd_in   = 5'd3;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp out_valid held", 32'(bus.out_valid), 32'd1);
      check("bp lcm held", 32'(bus.lcm), 32'd72);
      check("bp in_ready low", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp out_valid drop", 32'(bus.out_valid), 32'd0);
    check("bp no same-edge accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp next accepted", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bp next latency", 32'(lat), 32'd11);
    check("bp next lcm", 32'(bus.lcm), 32'd60);
    @(posedge clk);
    #1;

    // Reset during MUL drops the job and clears outputs asynchronously
    @(negedge clk);
    bus.A        = 5'd24;
    bus.B        = 5'd18;
    bus.gcd_in   = 5'd6;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    check("mid reset lcm", 32'(bus.lcm), 32'd0);
    check("mid reset err", 32'(bus.err), 32'd0);
    check("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    run_job(5'd10, 5'd15, 5'd5, lat);
    check("post reset latency", 32'(lat), 32'd11);
    check("post reset lcm", 32'(bus.lcm), 32'd30);
    check("post reset err", 32'(bus.err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
